// File: rtl/qconf_pkg.sv
// Shared types and address map for the per-function QCONF register block.
// Used by axil_qconf_regs and qconf_qid_lookup.
package qconf_pkg;

    typedef struct packed {
        logic [15:0] qbase;
        logic [15:0] qnum;
    } qconf_t;

    localparam logic [15:0] ADDR_ID      = 16'h0000;
    localparam logic [15:0] QCONF_STRIDE = 16'h1000;
    localparam logic [15:0] HITCNT_OFS   = 16'h0004;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic [15:0] qconf_addr(input int f);
        return 16'((f + 1) * int'(QCONF_STRIDE));
    endfunction

    // Word-granular address compare; byte offset bits are ignored.
    function automatic logic same_word(input logic [15:0] a, input logic [15:0] b);
        return (a & 16'hFFFC) == (b & 16'hFFFC);
    endfunction

endpackage

// File: rtl/qconf_qid_lookup.sv
// Registered priority match of a queue id against the per-function QCONF ranges.
// Lowest-numbered function whose [qbase, qbase+qnum) range contains qid wins.
module qconf_qid_lookup
    import qconf_pkg::*;
#(
    parameter int NUM_PHYS_FUNC = 2,
    parameter int QID_W         = 11,
    parameter int FID_W         = 1
)(
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           qid_valid,
    input  logic [QID_W-1:0]               qid,
    input  qconf_t [NUM_PHYS_FUNC-1:0]     qconf,
    output logic                           func_valid,
    output logic                           func_hit,
    output logic [FID_W-1:0]               func_id
);

    logic [NUM_PHYS_FUNC-1:0] match;
    logic [16:0]              qid_ext;
    logic                     func_valid_q, func_valid_d;
    logic                     func_hit_q, func_hit_d;
    logic [FID_W-1:0]         func_id_q, func_id_d;

    assign qid_ext = 17'(qid);

    // 17-bit compare so qbase+qnum never wraps; qnum=0 yields an empty range.
    generate
        for (genvar gi = 0; gi < NUM_PHYS_FUNC; gi++) begin : g_match
            logic [16:0] lo;
            logic [16:0] hi;
            assign lo = {1'b0, qconf[gi].qbase};
            assign hi = {1'b0, qconf[gi].qbase} + {1'b0, qconf[gi].qnum};
            assign match[gi] = (qid_ext >= lo) && (qid_ext < hi);
        end
    endgenerate

    always_comb begin
        func_valid_d = qid_valid;
        func_hit_d   = 1'b0;
        func_id_d    = '0;
        if (qid_valid) begin
            func_hit_d = |match;
            for (int f = NUM_PHYS_FUNC - 1; f >= 0; f--) begin
                if (match[f]) begin
                    func_id_d = FID_W'(f);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            func_valid_q <= 1'b0;
            func_hit_q   <= 1'b0;
            func_id_q    <= '0;
        end else begin
            func_valid_q <= func_valid_d;
            func_hit_q   <= func_hit_d;
            func_id_q    <= func_id_d;
        end
    end

    assign func_valid = func_valid_q;
    assign func_hit   = func_hit_q;
    assign func_id    = func_id_q;

endmodule

// File: rtl/axil_qconf_regs.sv
// AXI4-Lite responder for per-function QCONF words plus qid->function lookup.
// Optional per-function hit counters are built when QCONF_HIT_CNT_EN is defined.
module axil_qconf_regs
    import qconf_pkg::*;
#(
    parameter int          NUM_PHYS_FUNC = 2,
    parameter int          QID_W         = 11,
    parameter logic [31:0] ID_VALUE      = 32'h51434F4E,
    localparam int         FID_W         = (NUM_PHYS_FUNC > 1) ? $clog2(NUM_PHYS_FUNC) : 1
)(
    input  logic                          axil_aclk,
    input  logic                          axil_aresetn,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [31:0]                   s_axil_awaddr,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    input  logic [31:0]                   s_axil_wdata,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    output logic [1:0]                    s_axil_bresp,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    input  logic [31:0]                   s_axil_araddr,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic [31:0]                   s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    input  logic                          qid_valid,
    input  logic [QID_W-1:0]              qid,
    output logic                          func_valid,
    output logic                          func_hit,
    output logic [FID_W-1:0]              func_id,
    output logic [32*NUM_PHYS_FUNC-1:0]   qconf_flat
);

    qconf_t [NUM_PHYS_FUNC-1:0] qconf_q, qconf_d;
    logic                       rdy_en_q, rdy_en_d;
    logic                       aw_held_q, aw_held_d;
    logic [15:0]                aw_addr_q, aw_addr_d;
    logic                       w_held_q, w_held_d;
    logic [31:0]                w_data_q, w_data_d;
    logic                       bvalid_q, bvalid_d;
    logic [1:0]                 bresp_q, bresp_d;
    logic                       rvalid_q, rvalid_d;
    logic [31:0]                rdata_q, rdata_d;
    logic [1:0]                 rresp_q, rresp_d;
    logic                       commit;
    logic                       lk_valid, lk_hit;
    logic [FID_W-1:0]           lk_id;
    logic                       unused_addr_bits;

`ifdef QCONF_HIT_CNT_EN
    logic [NUM_PHYS_FUNC-1:0]        cnt_clr;
    logic [NUM_PHYS_FUNC-1:0][31:0]  hit_cnt_q, hit_cnt_d;
`endif

    assign unused_addr_bits = ^{s_axil_awaddr[31:16], s_axil_araddr[31:16]};

    // rdy_en_q keeps the ready outputs low while in reset and for the release cycle.
    assign s_axil_awready = rdy_en_q && !aw_held_q && !bvalid_q;
    assign s_axil_wready  = rdy_en_q && !w_held_q && !bvalid_q;
    assign s_axil_arready = rdy_en_q && !rvalid_q;
    assign commit         = aw_held_q && w_held_q;

    always_comb begin
        rdy_en_d  = 1'b1;
        aw_held_d = aw_held_q;
        aw_addr_d = aw_addr_q;
        w_held_d  = w_held_q;
        w_data_d  = w_data_q;
        bvalid_d  = bvalid_q;
        bresp_d   = bresp_q;
        rvalid_d  = rvalid_q;
        rdata_d   = rdata_q;
        rresp_d   = rresp_q;
        qconf_d   = qconf_q;
`ifdef QCONF_HIT_CNT_EN
        cnt_clr   = '0;
`endif
        if (s_axil_awvalid && s_axil_awready) begin
            aw_held_d = 1'b1;
            aw_addr_d = s_axil_awaddr[15:0];
        end
        if (s_axil_wvalid && s_axil_wready) begin
            w_held_d = 1'b1;
            w_data_d = s_axil_wdata;
        end

        if (commit) begin
            aw_held_d = 1'b0;
            w_held_d  = 1'b0;
            bvalid_d  = 1'b1;
            bresp_d   = RESP_SLVERR;
            for (int f = 0; f < NUM_PHYS_FUNC; f++) begin
                if (same_word(aw_addr_q, qconf_addr(f))) begin
                    qconf_d[f] = w_data_q;
                    bresp_d    = RESP_OKAY;
                end
`ifdef QCONF_HIT_CNT_EN
                if (same_word(aw_addr_q, qconf_addr(f) + HITCNT_OFS)) begin
                    cnt_clr[f] = 1'b1;
                    bresp_d    = RESP_OKAY;
                end
`endif
            end
        end else if (bvalid_q && s_axil_bready) begin
            bvalid_d = 1'b0;
        end

        // Read data is taken from the current-cycle registers, so a same-cycle
        // commit is not yet visible to the read.
        if (s_axil_arvalid && s_axil_arready) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = RESP_SLVERR;
            if (same_word(s_axil_araddr[15:0], ADDR_ID)) begin
                rdata_d = ID_VALUE;
                rresp_d = RESP_OKAY;
            end
            for (int f = 0; f < NUM_PHYS_FUNC; f++) begin
                if (same_word(s_axil_araddr[15:0], qconf_addr(f))) begin
                    rdata_d = qconf_q[f];
                    rresp_d = RESP_OKAY;
                end
`ifdef QCONF_HIT_CNT_EN
                if (same_word(s_axil_araddr[15:0], qconf_addr(f) + HITCNT_OFS)) begin
                    rdata_d = hit_cnt_q[f];
                    rresp_d = RESP_OKAY;
                end
`endif
            end
        end else if (rvalid_q && s_axil_rready) begin
            rvalid_d = 1'b0;
        end
    end

`ifdef QCONF_HIT_CNT_EN
    // Clear beats a same-cycle increment; counters saturate at all-ones.
    generate
        for (genvar gi = 0; gi < NUM_PHYS_FUNC; gi++) begin : g_hit_cnt
            always_comb begin
                hit_cnt_d[gi] = hit_cnt_q[gi];
                if (cnt_clr[gi]) begin
                    hit_cnt_d[gi] = '0;
                end else if (lk_valid && lk_hit && (lk_id == FID_W'(gi))
                             && (hit_cnt_q[gi] != 32'hFFFF_FFFF)) begin
                    hit_cnt_d[gi] = hit_cnt_q[gi] + 32'd1;
                end
            end
        end
    endgenerate

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            hit_cnt_q <= '0;
        end else begin
            hit_cnt_q <= hit_cnt_d;
        end
    end
`endif

    always_ff @(posedge axil_aclk or negedge axil_aresetn) begin
        if (!axil_aresetn) begin
            rdy_en_q  <= 1'b0;
            aw_held_q <= 1'b0;
            aw_addr_q <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
            qconf_q   <= '0;
        end else begin
            rdy_en_q  <= rdy_en_d;
            aw_held_q <= aw_held_d;
            aw_addr_q <= aw_addr_d;
            w_held_q  <= w_held_d;
            w_data_q  <= w_data_d;
            bvalid_q  <= bvalid_d;
            bresp_q   <= bresp_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
            qconf_q   <= qconf_d;
        end
    end

    assign s_axil_bvalid = bvalid_q;
    assign s_axil_bresp  = bresp_q;
    assign s_axil_rvalid = rvalid_q;
    assign s_axil_rdata  = rdata_q;
    assign s_axil_rresp  = rresp_q;

    generate
        for (genvar gi = 0; gi < NUM_PHYS_FUNC; gi++) begin : g_flat
            assign qconf_flat[32*gi +: 32] = qconf_q[gi];
        end
    endgenerate

    qconf_qid_lookup #(
        .NUM_PHYS_FUNC (NUM_PHYS_FUNC),
        .QID_W         (QID_W),
        .FID_W         (FID_W)
    ) u_lookup (
        .clk        (axil_aclk),
        .rst_n      (axil_aresetn),
        .qid_valid  (qid_valid),
        .qid        (qid),
        .qconf      (qconf_q),
        .func_valid (lk_valid),
        .func_hit   (lk_hit),
        .func_id    (lk_id)
    );

    assign func_valid = lk_valid;
    assign func_hit   = lk_hit;
    assign func_id    = lk_id;

endmodule

// File: tb/tb_axil_qconf_regs.sv
// Scoreboard bench for axil_qconf_regs: stimulus pushes expected B/R/lookup results
// from a behavioural model, a negedge monitor pops and compares.
`timescale 1ns/1ps
module tb_axil_qconf_regs;

    localparam int          NPF    = 2;
    localparam logic [31:0] ID_VAL = 32'h51434F4E;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        awvalid = 1'b0, awready;
    logic [31:0] awaddr = '0;
    logic        wvalid = 1'b0, wready;
    logic [31:0] wdata = '0;
    logic        bvalid, bready = 1'b1;
    logic [1:0]  bresp;
    logic        arvalid = 1'b0, arready;
    logic [31:0] araddr = '0;
    logic        rvalid, rready = 1'b1;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        qid_valid = 1'b0;
    logic [10:0] qid = '0;
    logic        func_valid, func_hit;
    logic [0:0]  func_id;
    logic [63:0] qconf_flat;

    always #5 clk = ~clk;

    axil_qconf_regs dut (
        .axil_aclk(clk), .axil_aresetn(rst_n),
        .s_axil_awvalid(awvalid), .s_axil_awready(awready), .s_axil_awaddr(awaddr),
        .s_axil_wvalid(wvalid), .s_axil_wready(wready), .s_axil_wdata(wdata),
        .s_axil_bvalid(bvalid), .s_axil_bready(bready), .s_axil_bresp(bresp),
        .s_axil_arvalid(arvalid), .s_axil_arready(arready), .s_axil_araddr(araddr),
        .s_axil_rvalid(rvalid), .s_axil_rready(rready), .s_axil_rdata(rdata), .s_axil_rresp(rresp),
        .qid_valid(qid_valid), .qid(qid),
        .func_valid(func_valid), .func_hit(func_hit), .func_id(func_id),
        .qconf_flat(qconf_flat)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] model_qconf [NPF];
    logic [31:0] model_cnt   [NPF];
    logic [1:0]  exp_b_q [$];
    logic [33:0] exp_r_q [$];
    logic [1:0]  exp_l_q [$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endfunction

    function automatic void fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s", name);
    endfunction

    function automatic void model_reset();
        for (int f = 0; f < NPF; f++) begin
            model_qconf[f] = '0;
            model_cnt[f]   = '0;
        end
    endfunction

    // Address map as plain integers: 0 = ID, k*0x1000 = QCONF[k-1], k*0x1000+4 = counter.
    function automatic logic [33:0] model_read(input logic [31:0] addr);
        int a = int'(addr[15:0] & 16'hFFFC);
        int k = a / 'h1000;
        if (a == 0) return {2'b00, ID_VAL};
        if (a % 'h1000 == 0 && k >= 1 && k <= NPF) return {2'b00, model_qconf[k-1]};
`ifdef QCONF_HIT_CNT_EN
        if (a % 'h1000 == 4 && k >= 1 && k <= NPF) return {2'b00, model_cnt[k-1]};
`endif
        return {2'b10, 32'h0};
    endfunction

    function automatic logic [1:0] model_write(input logic [31:0] addr, input logic [31:0] data);
        int a = int'(addr[15:0] & 16'hFFFC);
        int k = a / 'h1000;
        if (a % 'h1000 == 0 && k >= 1 && k <= NPF) begin
            model_qconf[k-1] = data;
            return 2'b00;
        end
`ifdef QCONF_HIT_CNT_EN
        if (a % 'h1000 == 4 && k >= 1 && k <= NPF) begin
            model_cnt[k-1] = '0;
            return 2'b00;
        end
`endif
        return 2'b10;
    endfunction

    function automatic logic [1:0] model_lookup(input int q);
        for (int f = 0; f < NPF; f++) begin
            int base = int'(model_qconf[f][31:16]);
            int num  = int'(model_qconf[f][15:0]);
            if (q >= base && q < base + num) begin
`ifdef QCONF_HIT_CNT_EN
                if (model_cnt[f] != 32'hFFFF_FFFF) model_cnt[f] = model_cnt[f] + 1;
`endif
                return {1'b1, 1'(f)};
            end
        end
        return 2'b00;
    endfunction

    // Monitor: one line per completed transaction, compare against queued expectations.
    always @(negedge clk) begin : mon
        logic [1:0]  eb;
        logic [33:0] er;
        logic [1:0]  el;
        if (rst_n) begin
            if (bvalid && bready) begin
                if (exp_b_q.size() == 0) fail_now("unexpected_bvalid");
                else begin
                    eb = exp_b_q.pop_front();
                    check("bresp", 64'(bresp), 64'(eb));
                    $display("B  bresp=%0d", bresp);
                end
            end
            if (rvalid && rready) begin
                if (exp_r_q.size() == 0) fail_now("unexpected_rvalid");
                else begin
                    er = exp_r_q.pop_front();
                    check("rdata_rresp", 64'({rresp, rdata}), 64'(er));
                    $display("R  rresp=%0d rdata=0x%08h", rresp, rdata);
                end
            end
            if (func_valid) begin
                if (exp_l_q.size() == 0) fail_now("unexpected_func_valid");
                else begin
                    el = exp_l_q.pop_front();
                    check("lookup_hit_id", 64'({func_hit, func_id}), 64'(el));
                    $display("LK hit=%0d id=%0d", func_hit, func_id);
                end
            end
        end
    end

    task automatic drive_aw(input logic [31:0] a, input int dly);
        repeat (dly) @(posedge clk);
        #1; awvalid = 1'b1; awaddr = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (awready) break;
        end
        if (!awready) fail_now("aw_handshake_timeout");
        @(posedge clk); #1; awvalid = 1'b0;
    endtask

    task automatic drive_w(input logic [31:0] d, input int dly);
        repeat (dly) @(posedge clk);
        #1; wvalid = 1'b1; wdata = d;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (wready) break;
        end
        if (!wready) fail_now("w_handshake_timeout");
        @(posedge clk); #1; wvalid = 1'b0;
    endtask

    task automatic write_txn(input logic [31:0] a, input logic [31:0] d, input int aw_dly, input int w_dly);
        exp_b_q.push_back(model_write(a, d));
        @(posedge clk);
        fork
            drive_aw(a, aw_dly);
            drive_w(d, w_dly);
        join
    endtask

    task automatic read_txn(input logic [31:0] a);
        exp_r_q.push_back(model_read(a));
        @(posedge clk);
        #1; arvalid = 1'b1; araddr = a;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (arready) break;
        end
        if (!arready) fail_now("ar_handshake_timeout");
        @(posedge clk); #1; arvalid = 1'b0;
    endtask

    task automatic lookup_burst(input int qs [$]);
        @(posedge clk);
        foreach (qs[i]) begin
            #1; qid_valid = 1'b1; qid = 11'(qs[i]);
            exp_l_q.push_back(model_lookup(qs[i]));
            @(posedge clk);
        end
        #1; qid_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_b_q.size() != 0 || exp_r_q.size() != 0 || exp_l_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            fail_now($sformatf("drain_timeout b=%0d r=%0d l=%0d", exp_b_q.size(), exp_r_q.size(), exp_l_q.size()));
            exp_b_q.delete(); exp_r_q.delete(); exp_l_q.delete();
        end
        @(negedge clk);
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog_timeout");
        $fatal(1, "simulation time limit");
    end

    initial begin : stim
        logic [31:0] old_val;
        logic [31:0] base_addrs [8];
        int n;
        base_addrs = '{32'h0000, 32'h1000, 32'h2000, 32'h3000, 32'h1004, 32'h2004, 32'h1008, 32'h0FFC};
        model_reset();

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'h0);
        check("rst_wready", 64'(wready), 64'h0);
        check("rst_arready", 64'(arready), 64'h0);
        check("rst_bvalid_rvalid", 64'({bvalid, rvalid}), 64'h0);
        check("rst_resp_rdata", 64'({bresp, rresp, rdata}), 64'h0);
        check("rst_func", 64'({func_valid, func_hit, func_id}), 64'h0);
        check("rst_qconf_flat", qconf_flat, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", 64'({awready, wready, arready}), 64'h7);

        // Basic programming and readback
        write_txn(32'h1000, 32'h0000_0001, 0, 0);
        write_txn(32'h2000, 32'h0002_0001, 0, 0);
        drain();
        read_txn(32'h1000);
        read_txn(32'h2000);
        drain();
        check("qconf_flat_prog", qconf_flat, 64'h0002_0001_0000_0001);

        // Back-to-back lookups: expect (1,0),(1,1),(0,0),(0,0)
        lookup_burst('{0, 2, 1, 3});
        drain();

        // ID register and unmapped space
        read_txn(32'h0000);
        write_txn(32'h0000, 32'hDEAD_BEEF, 0, 0);
        drain();
        read_txn(32'h0000);
        read_txn(32'h3000);
        read_txn(32'h1004);
        drain();

        // W well ahead of AW, then AW ahead of W
        write_txn(32'h1000, 32'h0003_0002, 5, 0);
        drain();
        write_txn(32'h2000, 32'h0007_0004, 0, 5);
        drain();
        read_txn(32'h1000);
        read_txn(32'h2000);
        drain();

        // Backpressure on B
        bready = 1'b0;
        write_txn(32'h2000, 32'h0002_0001, 0, 0);
        n = 0;
        while (!bvalid && n < 20) begin @(negedge clk); n++; end
        if (!bvalid) fail_now("bvalid_timeout");
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bvalid_held", 64'(bvalid), 64'h1);
            check("aw_w_blocked", 64'({awready, wready}), 64'h0);
        end
        bready = 1'b1;
        drain();

        // Read and write commit to 0x1000 in the same cycle
        old_val = model_qconf[0];
        exp_r_q.push_back({2'b00, old_val});
        exp_b_q.push_back(model_write(32'h1000, 32'h0005_0003));
        @(posedge clk);
        #1; awvalid = 1'b1; awaddr = 32'h1000; wvalid = 1'b1; wdata = 32'h0005_0003;
        @(negedge clk);
        check("aw_w_ready_same", 64'({awready, wready}), 64'h3);
        @(posedge clk);
        #1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b1; araddr = 32'h1000;
        @(negedge clk);
        check("arready_same", 64'(arready), 64'h1);
        @(posedge clk);
        #1; arvalid = 1'b0;
        drain();
        read_txn(32'h1000);
        drain();

`ifdef QCONF_HIT_CNT_EN
        // Hit counters
        write_txn(32'h2000, 32'h0002_0001, 0, 0);
        write_txn(32'h2004, 32'h0, 0, 0);
        drain();
        lookup_burst('{2, 2, 2});
        drain();
        read_txn(32'h2004);
        drain();
        write_txn(32'h2004, 32'h1234_5678, 0, 0);
        drain();
        read_txn(32'h2004);
        drain();
`endif

        // Randomized traffic
        for (int it = 0; it < 40; it++) begin
            logic [31:0] a;
            int qs [$];
            a = {16'($urandom), base_addrs[$urandom_range(0, 7)][15:0] | 16'($urandom_range(0, 3))};
            case ($urandom_range(0, 2))
                0: write_txn(a, {16'($urandom_range(0, 23)), 16'($urandom_range(0, 6))},
                             $urandom_range(0, 3), $urandom_range(0, 3));
                1: read_txn(a);
                default: begin
                    n = $urandom_range(1, 4);
                    for (int j = 0; j < n; j++)
                        qs.push_back(($urandom_range(0, 7) == 0) ? $urandom_range(0, 2047) : $urandom_range(0, 31));
                    lookup_burst(qs);
                end
            endcase
            drain();
        end

        // Reset while an AW beat is held
        write_txn(32'h1000, 32'h0009_0009, 0, 0);
        drain();
        @(posedge clk);
        #1; awvalid = 1'b1; awaddr = 32'h2000;
        @(negedge clk);
        @(posedge clk);
        #1; awvalid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check("midrst_qconf_flat", qconf_flat, 64'h0);
        check("midrst_bvalid", 64'(bvalid), 64'h0);
        rst_n = 1'b1;
        #1; wvalid = 1'b1; wdata = 32'hCAFE_0001;
        @(posedge clk);
        @(posedge clk);
        #1; wvalid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("postrst_no_bvalid", 64'(bvalid), 64'h0);
        end
        read_txn(32'h1000);
        read_txn(32'h2000);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
